fir_serial_mac: RTL and testbench

- Time-multiplexed 32-tap FIR engine; it is the reader side of the combinational coefficient ROM.
- Holds a circular 32-entry sample history and, per accepted sample, walks coef_addr 0..31.
- Multiplies each coefficient by the matching delayed sample, accumulates, then emits one rounded/saturated Q15 result.
- Sits between the ADC sample interface and the DAC/output register.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_serial_mac_if.sv | 23 ++
 rtl/fir_sample_buf.sv | 34 +++
 rtl/fir_serial_mac.sv | 102 ++++++++++
 tb/tb_fir_serial_mac.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and Q15 limits for the time-multiplexed 32-tap FIR engine.
package fir_pkg;

  localparam int TAPS  = 32;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACC_W = DW + CW + AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_t;

  localparam logic signed [DW-1:0]    Q15_MAX    = 16'sh7FFF;
  localparam logic signed [DW-1:0]    Q15_MIN    = 16'sh8000;
  localparam logic signed [ACC_W-1:0] SAT_HI     = ACC_W'(Q15_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO     = ACC_W'(Q15_MIN);
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(16384);

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample/result/coefficient-ROM signal bundle for fir_serial_mac; slave is the filter, master its environment.
interface fir_serial_mac_if;
  import fir_pkg::*;

  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 busy;

  modport slave (
    input  din_valid, din, coef_data,
    output coef_addr, dout, dout_valid, busy
  );

  modport master (
    output din_valid, din, coef_data,
    input  coef_addr, dout, dout_valid, busy
  );

endinterface

// File: rtl/fir_sample_buf.sv
// Circular 32-entry sample history: wrapping write pointer, newest-first combinational tap read at (base-k).
module fir_sample_buf
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        k,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [TAPS];
  logic [AW-1:0]        wp;
  logic [AW-1:0]        base;
  logic [AW-1:0]        rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      base <= '0;
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wp] <= wdata;
      base    <= wp;
      wp      <= wp + AW'(1);
    end
  end

  // AW-bit subtraction wraps naturally, so older samples sit at base-1, base-2, ...
  assign rd_idx = base - k;
  assign rdata  = mem[rd_idx];

endmodule

// File: rtl/fir_serial_mac.sv
// Serial 32-tap FIR: one MAC per cycle over the sample history, then a Q15 shift and saturation.
// Build option FIR_ROUND_EN: round half up before the >>>15 instead of truncating toward -inf.
module fir_serial_mac
  import fir_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fir_serial_mac_if.slave bus
);

  localparam int PW = DW + CW;

  fir_state_t              state_q, state_d;
  logic                    accept;
  logic [AW-1:0]           tap_k;
  logic signed [DW-1:0]    samp;
  logic signed [PW-1:0]    prod_p1;
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [DW-1:0]    dout_q;

  function automatic logic signed [ACC_W-1:0] q15_scale(input logic signed [ACC_W-1:0] a);
`ifdef FIR_ROUND_EN
    return (a + ROUND_HALF) >>> (CW - 1);
`else
    return a >>> (CW - 1);
`endif
  endfunction

  function automatic logic signed [DW-1:0] sat_q15(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return Q15_MAX;
    else if (a < SAT_LO) return Q15_MIN;
    else                 return a[DW-1:0];
  endfunction

  fir_sample_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .wdata (bus.din),
    .k     (tap_k),
    .rdata (samp)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          accept  = 1'b1;
          state_d = MAC;
        end
      end
      MAC:     if (tap_k == AW'(TAPS - 1)) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_sum = acc_p2 + ACC_W'(prod_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_k   <= '0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      dout_q  <= '0;
    end else begin
      // p0 -> p1: coefficient times delayed sample
      vld_p1 <= (state_q == MAC);
      if (accept)
        tap_k <= '0;
      else if (state_q == MAC && tap_k != AW'(TAPS - 1))
        tap_k <= tap_k + AW'(1);
      if (state_q == MAC)
        prod_p1 <= PW'(bus.coef_data) * PW'(samp);

      // p1 -> p2: accumulate; the DRAIN cycle folds in the last product and publishes the result
      if (accept)
        acc_p2 <= '0;
      else if (vld_p1)
        acc_p2 <= acc_sum;
      if (state_q == DRAIN)
        dout_q <= sat_q15(q15_scale(acc_sum));
    end
  end

  assign bus.coef_addr  = tap_k;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == OUT);
  assign bus.busy       = (state_q == MAC) || (state_q == DRAIN);

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: a convolution model over accepted samples feeds an expected-output queue.
module tb_fir_serial_mac;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_serial_mac_if bus ();

  fir_serial_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [CW-1:0] h [TAPS];
  always_comb bus.coef_data = h[bus.coef_addr];

  logic signed [DW-1:0] hist  [$];
  logic signed [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // y[n] = sum_j h[j]*x[n-j], samples before the last reset count as zero
  task automatic model_accept(input logic signed [DW-1:0] x);
    longint s;
    logic signed [DW-1:0] y;
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
    s = 0;
    for (int j = 0; j < hist.size(); j++) s += longint'(h[j]) * longint'(hist[j]);
`ifdef FIR_ROUND_EN
    s += 16384;
`endif
    s = s >>> 15;
    if (s > 32767)       y = 16'sh7FFF;
    else if (s < -32768) y = 16'sh8000;
    else                 y = DW'(s);
    exp_q.push_back(y);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout_valid: got dout %0h with dout_valid=1, expected no output", bus.dout);
      end else begin
        check("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic set_h_all(input logic signed [CW-1:0] v);
    for (int i = 0; i < TAPS; i++) h[i] = v;
  endtask

  task automatic set_h_rand();
    for (int i = 0; i < TAPS; i++) h[i] = CW'($urandom);
  endtask

  // Entered at a negedge of an idle cycle; returns at the negedge of the earliest next accept cycle.
  task automatic send(input logic signed [DW-1:0] x, input int drop_a, input int drop_b);
    bit ok = 1'b1;
    int bad_c = 0;
    logic bad_busy = 1'b0;
    logic bad_dv = 1'b0;
    logic [AW-1:0] bad_addr = '0;
    bus.din = x;
    bus.din_valid = 1'b1;
    model_accept(x);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (ok && ((c < 34 && (bus.busy !== 1'b1 || bus.dout_valid !== 1'b0)) ||
                 (c == 34 && (bus.busy !== 1'b0 || bus.dout_valid !== 1'b1 ||
                              bus.coef_addr !== AW'(TAPS - 1))))) begin
        ok = 1'b0;
        bad_c = c;
        bad_busy = bus.busy;
        bad_dv = bus.dout_valid;
        bad_addr = bus.coef_addr;
      end
      bus.din_valid = (c == drop_a) || (c == drop_b);
      if (bus.din_valid) bus.din = 16'sh7FFF;
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake: at T+%0d got busy=%b dout_valid=%b coef_addr=%0d, expected busy=%b dout_valid=%b (coef_addr 31 at T+34)",
               bad_c, bad_busy, bad_dv, bad_addr, (bad_c < 34), (bad_c == 34));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.din = '0;
    set_h_all('0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_dout", 32'(bus.dout), 32'(0));
    check("reset_dout_valid", 32'(bus.dout_valid), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_coef_addr", 32'(bus.coef_addr), 32'(0));

    // Latency and handshake with a single unity-ish tap
    h[0] = 16'sh7FFF;
    send(16'sh1234, 0, 0);

    // Tap alignment through the wrap of the write pointer
    apply_reset();
    set_h_all('0);
    h[5] = 16'sh7FFF;
    send(16'sh4000, 0, 0);
    for (int i = 0; i < 39; i++) send('0, 0, 0);

    // Positive saturation
    apply_reset();
    set_h_all(16'sh4000);
    for (int i = 0; i < TAPS; i++) send(16'sh2000, 0, 0);

    // Negative saturation
    apply_reset();
    set_h_all(16'sh8000);
    for (int i = 0; i < TAPS; i++) send(16'sh7FFF, 0, 0);

    // Overrun pulses are dropped
    apply_reset();
    set_h_rand();
    send(DW'($urandom), 10, 34);
    send(DW'($urandom), 0, 0);
    send(DW'($urandom), 1, 33);

    // Randomized stream with random dropped strobes
    set_h_rand();
    for (int i = 0; i < 60; i++) send(DW'($urandom), $urandom_range(0, 34), $urandom_range(0, 34));

    // Reset in the middle of a computation
    bus.din = DW'($urandom);
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_dout", 32'(bus.dout), 32'(0));
    check("abort_dout_valid", 32'(bus.dout_valid), 32'(0));
    repeat (40) @(negedge clk);
    set_h_rand();
    send('0, 0, 0);
    set_h_all('0);
    h[0] = 16'sh7FFF;
    send('0, 0, 0);

    repeat (5) @(negedge clk);
    check("pending_outputs", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
